// File: rtl/sram_arb_bridge_pkg.sv
// -----------------------------------------------------------------------------
// sram_arb_bridge_pkg
// Shared definitions for the SRAM arbiter/bridge:
//   arb_state_e  - arbitration state (ARB_IDLE = free grant, ARB_HOLD = locked)
//   ch_id_width  - width of a channel id for a given channel count
//   slice_lo     - low bit index of slice idx in a flattened bus of width w
// -----------------------------------------------------------------------------
package sram_arb_bridge_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    // A lone channel would give clog2 = 0, so keep at least one id bit.
    function automatic int ch_id_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/sram_arb_bridge_id_fifo.sv
// -----------------------------------------------------------------------------
// sram_arb_id_fifo
// In-order FIFO of channel ids, one entry per outstanding memory transaction.
// Ports:
//   clk, rst      - clock, asynchronous active-low reset
//   push, push_id - enqueue the id of a just-accepted request
//   pop           - dequeue the head when its response returns
//   full, empty   - occupancy flags
//   head          - id of the oldest outstanding transaction
// A push while full and a pop while empty are ignored.
// -----------------------------------------------------------------------------
module sram_arb_id_fifo
    import sram_arb_bridge_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ID_W  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [ID_W-1:0] push_id,
    input  logic            pop,
    output logic            full,
    output logic            empty,
    output logic [ID_W-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ID_W-1:0]  slots_q [DEPTH];
    logic [ID_W-1:0]  slots_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = slots_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        slots_d  = slots_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            slots_d[wr_ptr_q] = push_id;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slots_q  <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            slots_q  <= slots_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sram_arb_bridge.sv
// -----------------------------------------------------------------------------
// sram_arb_bridge
// Round-robin arbiter/bridge from NUM_CH SRAM-like masters (0 = IF, 1 = MEM)
// onto one split-transaction memory port (addr_ok / data_ok handshakes).
// Ports:
//   clk, rst                    - clock, asynchronous active-low reset
//   ch_req/wr/wstrb/addr/wdata  - per-channel requests, flattened buses
//   ch_addr_ok, ch_data_ok      - per-channel accept / response strobes
//   ch_rdata                    - shared read data, valid with ch_data_ok
//   ch_stallreq                 - per-channel stall request to CTRL
//   mem_*                       - shared memory port
//   err_spurious                - sticky: response arrived with nothing pending
// Optional feature (macro SRAM_ARB_PERF_EN): perf_sel, perf_clr, perf_acc,
// perf_stall - saturating per-channel accept / stall-cycle counters.
// -----------------------------------------------------------------------------
module sram_arb_bridge
    import sram_arb_bridge_pkg::*;
#(
    parameter int NUM_CH          = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          ch_req,
    input  logic [NUM_CH-1:0]          ch_wr,
    input  logic [NUM_CH*DATA_W/8-1:0] ch_wstrb,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
    output logic [NUM_CH-1:0]          ch_addr_ok,
    output logic [NUM_CH-1:0]          ch_data_ok,
    output logic [DATA_W-1:0]          ch_rdata,
    output logic [NUM_CH-1:0]          ch_stallreq,
    output logic                       mem_req,
    output logic                       mem_wr,
    output logic [DATA_W/8-1:0]        mem_wstrb,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic                       mem_addr_ok,
    input  logic                       mem_data_ok,
    input  logic [DATA_W-1:0]          mem_rdata,
`ifdef SRAM_ARB_PERF_EN
    input  logic [ch_id_width(NUM_CH)-1:0] perf_sel,
    input  logic                       perf_clr,
    output logic [31:0]                perf_acc,
    output logic [31:0]                perf_stall,
`endif
    output logic                       err_spurious
);

    localparam int CH_ID_W = ch_id_width(NUM_CH);
    localparam int STRB_W  = DATA_W / 8;

    arb_state_e         state_q, state_d;
    logic [CH_ID_W-1:0] grant_q, grant_d;
    logic [CH_ID_W-1:0] rr_q, rr_d;
    logic               err_q, err_d;
    logic [CH_ID_W-1:0] idle_grant, cand, grant;
    logic               any_req, accept, pop;
    logic               fifo_full, fifo_empty;
    logic [CH_ID_W-1:0] fifo_head;

    // Walk from the farthest offset back to rr_q so the closest requester
    // at/after the round-robin pointer is the last (winning) assignment.
    always_comb begin
        idle_grant = rr_q;
        cand       = rr_q;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            cand = CH_ID_W'((int'(rr_q) + i) % NUM_CH);
            if (ch_req[cand]) begin
                idle_grant = cand;
            end
        end
    end

    // Grant selection, memory-port drive, handshakes and next state. All
    // outputs are gated by rst so they read zero while reset is asserted.
    // A full FIFO blocks new requests even if a response pops this cycle.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        err_d   = err_q;

        grant   = (state_q == ARB_HOLD) ? grant_q : idle_grant;
        any_req = (state_q == ARB_HOLD) ? ch_req[grant_q] : (|ch_req);
        mem_req = rst & any_req & ~fifo_full;
        accept  = mem_req & mem_addr_ok;
        pop     = mem_data_ok & ~fifo_empty;

        mem_wr    = rst & ch_wr[grant];
        mem_wstrb = rst ? ch_wstrb[slice_lo(int'(grant), STRB_W) +: STRB_W] : '0;
        mem_addr  = rst ? ch_addr[slice_lo(int'(grant), ADDR_W) +: ADDR_W] : '0;
        mem_wdata = rst ? ch_wdata[slice_lo(int'(grant), DATA_W) +: DATA_W] : '0;

        ch_addr_ok = '0;
        if (accept) begin
            ch_addr_ok[grant] = 1'b1;
        end
        ch_data_ok = '0;
        if (pop) begin
            ch_data_ok[fifo_head] = 1'b1;
        end
        ch_rdata    = pop ? mem_rdata : '0;
        ch_stallreq = rst ? (ch_req & ~ch_addr_ok) : '0;

        if (accept) begin
            rr_d    = CH_ID_W'((int'(grant) + 1) % NUM_CH);
            state_d = ARB_IDLE;
        end else if (mem_req) begin
            state_d = ARB_HOLD;
            grant_d = grant;
        end

        if (mem_data_ok && fifo_empty) begin
            err_d = 1'b1;
        end
        err_spurious = err_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
        end
    end

    sram_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .ID_W  (CH_ID_W)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (accept),
        .push_id (grant),
        .pop     (pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

`ifdef SRAM_ARB_PERF_EN
    logic [31:0] acc_q   [NUM_CH];
    logic [31:0] acc_d   [NUM_CH];
    logic [31:0] stall_q [NUM_CH];
    logic [31:0] stall_d [NUM_CH];

    // Saturating per-channel counters; perf_clr wins over counting.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            acc_d[i]   = acc_q[i];
            stall_d[i] = stall_q[i];
            if (perf_clr) begin
                acc_d[i]   = '0;
                stall_d[i] = '0;
            end else begin
                if (accept && (grant == CH_ID_W'(i)) && (acc_q[i] != '1)) begin
                    acc_d[i] = acc_q[i] + 32'd1;
                end
                if (ch_stallreq[i] && (stall_q[i] != '1)) begin
                    stall_d[i] = stall_q[i] + 32'd1;
                end
            end
        end
        perf_acc   = acc_q[perf_sel];
        perf_stall = stall_q[perf_sel];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q   <= '{default: '0};
            stall_q <= '{default: '0};
        end else begin
            acc_q   <= acc_d;
            stall_q <= stall_d;
        end
    end
`endif

endmodule

// File: tb/tb_sram_arb_bridge.sv
// -----------------------------------------------------------------------------
// tb_sram_arb_bridge
// Directed scenarios followed by a randomized phase. Expected outputs come from
// a transaction-level model: a queue of outstanding channel ids, a round-robin
// pointer, a locked-channel marker and a sticky error flag.
// -----------------------------------------------------------------------------
module tb_sram_arb_bridge;

    localparam int NUM_CH  = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int MAX_OUT = 4;
    localparam int STRB_W  = DATA_W / 8;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH-1:0]        ch_wr;
    logic [NUM_CH*STRB_W-1:0] ch_wstrb;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*DATA_W-1:0] ch_wdata;
    logic [NUM_CH-1:0]        ch_addr_ok;
    logic [NUM_CH-1:0]        ch_data_ok;
    logic [DATA_W-1:0]        ch_rdata;
    logic [NUM_CH-1:0]        ch_stallreq;
    logic                     mem_req;
    logic                     mem_wr;
    logic [STRB_W-1:0]        mem_wstrb;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic                     mem_addr_ok;
    logic                     mem_data_ok;
    logic [DATA_W-1:0]        mem_rdata;
    logic                     err_spurious;
`ifdef SRAM_ARB_PERF_EN
    logic [0:0]               perf_sel = 1'b0;
    logic                     perf_clr = 1'b0;
    logic [31:0]              perf_acc;
    logic [31:0]              perf_stall;
`endif

    always #5 clk = ~clk;

    sram_arb_bridge #(
        .NUM_CH          (NUM_CH),
        .ADDR_W          (ADDR_W),
        .DATA_W          (DATA_W),
        .MAX_OUTSTANDING (MAX_OUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ch_req       (ch_req),
        .ch_wr        (ch_wr),
        .ch_wstrb     (ch_wstrb),
        .ch_addr      (ch_addr),
        .ch_wdata     (ch_wdata),
        .ch_addr_ok   (ch_addr_ok),
        .ch_data_ok   (ch_data_ok),
        .ch_rdata     (ch_rdata),
        .ch_stallreq  (ch_stallreq),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata),
`ifdef SRAM_ARB_PERF_EN
        .perf_sel     (perf_sel),
        .perf_clr     (perf_clr),
        .perf_acc     (perf_acc),
        .perf_stall   (perf_stall),
`endif
        .err_spurious (err_spurious)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int modelQ[$];
    int modelRr;
    int modelLock;
    bit modelErr;

    // Expectations of the cycle being checked, reused by updateModel
    int expGrant;
    bit expMemReq;
    bit expAccept;

    bit pending[NUM_CH];

    // One comparison; a mismatch is counted and reported on a single line.
    task automatic compareValue(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int ch, input bit req, input bit wr,
                                 input logic [STRB_W-1:0] strb,
                                 input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] wdata);
        ch_req[ch]                        = req;
        ch_wr[ch]                         = wr;
        ch_wstrb[ch*STRB_W +: STRB_W]     = strb;
        ch_addr[ch*ADDR_W +: ADDR_W]      = addr;
        ch_wdata[ch*DATA_W +: DATA_W]     = wdata;
    endtask

    task automatic setMem(input bit aok, input bit dok, input logic [DATA_W-1:0] rdata);
        mem_addr_ok = aok;
        mem_data_ok = dok;
        mem_rdata   = rdata;
    endtask

    task automatic clearInputs();
        ch_req   = '0;
        ch_wr    = '0;
        ch_wstrb = '0;
        ch_addr  = '0;
        ch_wdata = '0;
        setMem(1'b0, 1'b0, '0);
    endtask

    task automatic modelReset();
        modelQ.delete();
        modelRr   = 0;
        modelLock = -1;
        modelErr  = 1'b0;
        for (int c = 0; c < NUM_CH; c++) pending[c] = 1'b0;
    endtask

    // Locked channel if one is held, else first requester at/after rr.
    function automatic int modelGrant();
        if (modelLock >= 0) return modelLock;
        for (int k = 0; k < NUM_CH; k++) begin
            int c;
            c = (modelRr + k) % NUM_CH;
            if (ch_req[c]) return c;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag);
        logic [NUM_CH-1:0] eAddrOk;
        logic [NUM_CH-1:0] eDataOk;
        bit full;
        bit anyReq;
        bit pop;
        expGrant  = modelGrant();
        full      = (modelQ.size() >= MAX_OUT);
        anyReq    = (modelLock >= 0) ? ch_req[modelLock] : (expGrant >= 0);
        expMemReq = anyReq && !full;
        expAccept = expMemReq && mem_addr_ok;
        pop       = mem_data_ok && (modelQ.size() > 0);
        eAddrOk   = expAccept ? (NUM_CH'(1) << expGrant) : '0;
        eDataOk   = pop ? (NUM_CH'(1) << modelQ[0]) : '0;
        compareValue({tag, ".mem_req"}, mem_req, expMemReq);
        compareValue({tag, ".addr_ok"}, ch_addr_ok, eAddrOk);
        compareValue({tag, ".data_ok"}, ch_data_ok, eDataOk);
        compareValue({tag, ".stallreq"}, ch_stallreq, ch_req & ~eAddrOk);
        compareValue({tag, ".err"}, err_spurious, modelErr);
        if (expMemReq) begin
            compareValue({tag, ".mem_addr"}, mem_addr, ch_addr[expGrant*ADDR_W +: ADDR_W]);
            compareValue({tag, ".mem_wr"}, mem_wr, ch_wr[expGrant]);
            compareValue({tag, ".mem_wstrb"}, mem_wstrb, ch_wstrb[expGrant*STRB_W +: STRB_W]);
            compareValue({tag, ".mem_wdata"}, mem_wdata, ch_wdata[expGrant*DATA_W +: DATA_W]);
        end
        if (pop) begin
            compareValue({tag, ".rdata"}, ch_rdata, mem_rdata);
        end
    endtask

    task automatic updateModel();
        if (mem_data_ok) begin
            if (modelQ.size() == 0) modelErr = 1'b1;
            else void'(modelQ.pop_front());
        end
        if (expAccept) begin
            modelQ.push_back(expGrant);
            modelRr   = (expGrant + 1) % NUM_CH;
            modelLock = -1;
        end else if (expMemReq) begin
            modelLock = expGrant;
        end
    endtask

    // Inputs are set just after a rising edge; outputs are checked on the
    // falling edge and the model advances on the next rising edge.
    task automatic runCycle(input string tag);
        @(negedge clk);
        checkOutput(tag);
        @(posedge clk);
        updateModel();
        #1;
    endtask

    task automatic checkZero(input string tag);
        compareValue({tag, ".mem_req"}, mem_req, '0);
        compareValue({tag, ".mem_wr"}, mem_wr, '0);
        compareValue({tag, ".mem_wstrb"}, mem_wstrb, '0);
        compareValue({tag, ".mem_addr"}, mem_addr, '0);
        compareValue({tag, ".mem_wdata"}, mem_wdata, '0);
        compareValue({tag, ".addr_ok"}, ch_addr_ok, '0);
        compareValue({tag, ".data_ok"}, ch_data_ok, '0);
        compareValue({tag, ".rdata"}, ch_rdata, '0);
        compareValue({tag, ".stallreq"}, ch_stallreq, '0);
        compareValue({tag, ".err"}, err_spurious, '0);
    endtask

    task automatic doReset();
        rst = 1'b0;
        clearInputs();
        modelReset();
        #1;
        checkZero("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not terminate");
    end

    initial begin
        rst = 1'b0;
        clearInputs();
        modelReset();
        #2;
        checkZero("por");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single read from channel 0, response on the following cycle
        applyStimulus(0, 1'b1, 1'b0, 4'h0, 32'h1000, 32'h0);
        setMem(1'b1, 1'b0, 32'h0);
        runCycle("read_req");
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        setMem(1'b0, 1'b1, 32'hDEADBEEF);
        runCycle("read_rsp");
        setMem(1'b0, 1'b0, 32'h0);
        runCycle("read_idle");

        // Both channels contend every cycle right after reset
        doReset();
        applyStimulus(0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 4'h0, 32'h200, 32'h0);
        setMem(1'b1, 1'b0, 32'h0);
        runCycle("cont_first");
        for (int i = 0; i < 6; i++) begin
            setMem(1'b1, 1'b1, 32'hA000 + i);
            runCycle("cont");
        end
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        setMem(1'b0, 1'b1, 32'hB000);
        runCycle("cont_drain");
        setMem(1'b0, 1'b0, 32'h0);
        runCycle("cont_idle");

        // Grant locked on channel 0 while memory stalls; channel 1 waits
        applyStimulus(0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        setMem(1'b0, 1'b0, 32'h0);
        runCycle("hold0");
        applyStimulus(1, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
        runCycle("hold1");
        runCycle("hold2");
        setMem(1'b1, 1'b0, 32'h0);
        runCycle("hold_acc0");
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        runCycle("hold_acc1");
        applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        setMem(1'b0, 1'b1, 32'h1111);
        runCycle("hold_rsp0");
        setMem(1'b0, 1'b1, 32'h2222);
        runCycle("hold_rsp1");
        setMem(1'b0, 1'b0, 32'h0);

        // Fill the tracking FIFO, then free one slot
        applyStimulus(0, 1'b1, 1'b0, 4'h0, 32'h300, 32'h0);
        setMem(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < MAX_OUT + 1; i++) runCycle("full_fill");
        setMem(1'b1, 1'b1, 32'hF00D);
        runCycle("full_pop");
        setMem(1'b1, 1'b0, 32'h0);
        runCycle("full_resume");
        applyStimulus(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < MAX_OUT; i++) begin
            setMem(1'b0, 1'b1, 32'hC000 + i);
            runCycle("full_drain");
        end

        // Write from channel 1
        applyStimulus(1, 1'b1, 1'b1, 4'h3, 32'h80, 32'h1234);
        setMem(1'b1, 1'b0, 32'h0);
        runCycle("write_req");
        applyStimulus(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        setMem(1'b0, 1'b1, 32'h5555);
        runCycle("write_rsp");
        setMem(1'b0, 1'b0, 32'h0);

        // Randomized traffic; masters hold a request until it is accepted
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!pending[c] && ($urandom_range(0, 1) == 1)) begin
                    applyStimulus(c, 1'b1, 1'($urandom_range(0, 1)), 4'($urandom),
                                  $urandom, $urandom);
                    pending[c] = 1'b1;
                end
            end
            setMem($urandom_range(0, 3) != 0,
                   (modelQ.size() > 0) && ($urandom_range(0, 1) == 1), $urandom);
            runCycle("rand");
            for (int c = 0; c < NUM_CH; c++) begin
                if (expAccept && (expGrant == c)) begin
                    pending[c] = 1'b0;
                    applyStimulus(c, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
                end
            end
        end
        clearInputs();
        for (int k = 0; (k < MAX_OUT + 2) && (modelQ.size() > 0); k++) begin
            setMem(1'b0, 1'b1, 32'hE000 + k);
            runCycle("rand_drain");
        end
        setMem(1'b0, 1'b0, 32'h0);
        runCycle("rand_idle");

        // Reset with two transactions outstanding
        applyStimulus(0, 1'b1, 1'b0, 4'h0, 32'h400, 32'h0);
        setMem(1'b1, 1'b0, 32'h0);
        runCycle("mid_acc0");
        runCycle("mid_acc1");
        setMem(1'b0, 1'b1, 32'h77);
        rst = 1'b0;
        #1;
        checkZero("mid_reset");
        clearInputs();
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        setMem(1'b0, 1'b1, 32'h99);
        runCycle("spurious");
        setMem(1'b0, 1'b0, 32'h0);
        runCycle("spurious_sticky");
        runCycle("spurious_sticky2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_arb_bridge.md
Name: sram_arb_bridge

Overview:
Parametrised N-channel arbiter/bridge between the core's SRAM-like masters (IF fetch, MEM load/store, and later more channels) and one shared memory port with request/response handshakes. It replaces fixed single-cycle inst/data SRAM ports with addr_ok/data_ok split transactions and tracks up to MAX_OUTSTANDING in-order transactions. It drives per-channel stall requests into CTRL.

Parameters:
NUM_CH, 2, number of master channels (2..8); channel 0 = IF, 1 = MEM
ADDR_W, 32, address width
DATA_W, 32, data width (multiple of 8)
MAX_OUTSTANDING, 4, response-tracking FIFO depth (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
ch_req  in  NUM_CH  per-channel request
ch_wr  in  NUM_CH  1 = write
ch_wstrb  in  NUM_CH*DATA_W/8  byte strobes, channel i at slice i
ch_addr  in  NUM_CH*ADDR_W  addresses
ch_wdata  in  NUM_CH*DATA_W  write data
ch_addr_ok  out  NUM_CH  request accepted this cycle
ch_data_ok  out  NUM_CH  response returned this cycle
ch_rdata  out  DATA_W  read data, shared, valid with ch_data_ok
ch_stallreq  out  NUM_CH  ch_req & ~ch_addr_ok
mem_req  out  1  memory request
mem_wr  out  1  write
mem_wstrb  out  DATA_W/8  strobes
mem_addr  out  ADDR_W  address
mem_wdata  out  DATA_W  write data
mem_addr_ok  in  1  memory accepted request
mem_data_ok  in  1  memory response
mem_rdata  in  DATA_W  response data
err_spurious  out  1  sticky: mem_data_ok with nothing outstanding

Behaviour:
- Reset (rst=0, async): FIFO empty, rr pointer 0, arb state IDLE, err_spurious 0; all outputs 0 combinationally once state is cleared.
- States: IDLE (free grant), HOLD (grant locked). IDLE: grant = first requesting channel at/after rr pointer (round-robin). If mem_req & ~mem_addr_ok -> HOLD with that grant registered. HOLD: grant fixed; mem_* driven from locked channel even if another channel raises ch_req; on mem_addr_ok -> IDLE. A master must hold req/addr/data stable until addr_ok.
- mem_req = |ch_req (IDLE) or ch_req[grant] (HOLD), forced 0 when FIFO full. Full blocks even if mem_data_ok pops that cycle (no same-cycle refill).
- Accept = mem_req & mem_addr_ok: ch_addr_ok[grant]=1 (combinational, same cycle); push grant id into FIFO; rr pointer <= grant+1 mod NUM_CH.
- Response: mem_data_ok & ~empty pops head; ch_data_ok[head]=1, ch_rdata = mem_rdata, same cycle, zero added latency. Writes also receive data_ok; rdata is don't-care.
- Simultaneous push and pop when not full: count unchanged, both applied.
- mem_data_ok while empty: ignored, no ch_data_ok, err_spurious <= 1 until reset.
- Minimum round trip: addr_ok cycle N, data_ok earliest cycle N+1 (memory-defined).
- Pointer arithmetic wraps mod MAX_OUTSTANDING; count width clog2(MAX_OUTSTANDING)+1.

Optional Feature:
SRAM_ARB_PERF_EN: adds inputs perf_sel (clog2(NUM_CH)) and perf_clr, and output perf_acc/perf_stall (32 bits each): per-channel counts of accepted requests and ch_stallreq cycles, saturating at 0xFFFFFFFF, cleared by reset or perf_clr. Without the macro, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package: CH_ID_W = clog2(NUM_CH), arb state encoding (IDLE=0, HOLD=1), slice-index helpers for flattened buses.
- Sub-module sram_arb_id_fifo: synchronous FIFO of channel IDs (push, pop, full, empty, head), depth MAX_OUTSTANDING, async active-low reset.

Test Plan:
- Single read: ch0 req addr 0x1000, mem_addr_ok=1 same cycle, mem_data_ok next cycle rdata 0xDEADBEEF -> ch_addr_ok[0] cycle N, ch_data_ok[0] N+1 with 0xDEADBEEF, ch_data_ok[1]=0.
- Contention after reset: ch0 and ch1 req every cycle, mem_addr_ok=1 -> grants alternate 0,1,0,1; responses route by FIFO order.
- Hold: ch0 req addr 0x20, mem_addr_ok low 3 cycles, ch1 req from cycle 1 -> mem_addr stays 0x20, ch_stallreq[1]=1 throughout; ch1 granted after ch0 accepted.
- Full: MAX_OUTSTANDING=4, mem_data_ok=0 -> 4 accepts, then mem_req=0; one mem_data_ok -> ch_data_ok to first requester; next cycle mem_req resumes.
- Reset mid-flight: 2 outstanding, assert rst=0 -> all outputs 0 immediately; after release a subsequent mem_data_ok sets err_spurious=1.
- Write: ch1 wr=1, wstrb 0x3, wdata 0x1234 -> mem_wr=1, mem_wstrb=0x3, mem_wdata=0x1234; ch_data_ok[1] on response.
